// File: rtl/adder_pkg.sv
// Shared constants and configuration helpers for the pipelined adder.
// Default geometry is 16 bits split into 4-bit slices, one slice per stage.
package adder_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_STAGE_W = 4;
    localparam int DEF_STAGES  = DEF_WIDTH / DEF_STAGE_W;

    function automatic int num_stages(input int width, input int stage_w);
        return (stage_w >= 1) ? (width / stage_w) : 1;
    endfunction

    function automatic bit cfg_ok(input int width, input int stage_w);
        return (stage_w >= 1) && (width >= stage_w) && ((width % stage_w) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// The master modport drives operands and consumes results; the slave is the adder.
interface pipe_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/adder_slice.sv
// Combinational W-bit ripple adder slice; also reports the carry into its MSB
// so the final slice can produce signed overflow.
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);
    logic c;

    always_comb begin
        c    = cin;
        s    = '0;
        cmsb = 1'b0;
        for (int i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            cmsb = c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: one STAGE_W slice per stage, carry registered
// between stages, valid/ready handshake with a single global stall.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int STAGE_W = DEF_STAGE_W
) (
    input  logic        clk,
    input  logic        rst,
    pipe_adder_if.slave bus
);
    localparam int STAGES = num_stages(WIDTH, STAGE_W);

    if (!cfg_ok(WIDTH, STAGE_W)) begin : g_cfg_check
        $error("pipe_adder: WIDTH (%0d) must be a positive multiple of STAGE_W (%0d)",
               WIDTH, STAGE_W);
    end

    logic stall;

    // Stage k keeps the low (k+1) result slices (deskew) and the operand
    // slices not yet consumed (skew); both shrink/grow by one slice per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SUM_W = (k + 1) * STAGE_W;

        logic               v_in;
        logic               c_in;
        logic [STAGE_W-1:0] op_a;
        logic [STAGE_W-1:0] op_b;
        logic [STAGE_W-1:0] slice_s;
        logic               slice_c;
        logic               msb_c;
        logic [SUM_W-1:0]   next_sum;
        logic               v_q;
        logic               c_q;
        logic [SUM_W-1:0]   sum_q;

        if (k == 0) begin : g_src
            assign v_in     = bus.in_valid;
            assign c_in     = bus.cin;
            assign op_a     = bus.a[STAGE_W-1:0];
            assign op_b     = bus.b[STAGE_W-1:0];
            assign next_sum = slice_s;
        end else begin : g_src
            assign v_in     = g_stage[k-1].v_q;
            assign c_in     = g_stage[k-1].c_q;
            assign op_a     = g_stage[k-1].g_mid.a_q[STAGE_W-1:0];
            assign op_b     = g_stage[k-1].g_mid.b_q[STAGE_W-1:0];
            assign next_sum = {slice_s, g_stage[k-1].sum_q};
        end

        adder_slice #(.W(STAGE_W)) u_slice (
            .a    (op_a),
            .b    (op_b),
            .cin  (c_in),
            .s    (slice_s),
            .cout (slice_c),
            .cmsb (msb_c)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (!stall) begin
                v_q   <= v_in;
                c_q   <= slice_c;
                sum_q <= next_sum;
            end
        end

        if (k < STAGES - 1) begin : g_mid
            localparam int FWD_W = WIDTH - SUM_W;

            logic [FWD_W-1:0] a_q;
            logic [FWD_W-1:0] b_q;
            logic [FWD_W-1:0] a_nxt;
            logic [FWD_W-1:0] b_nxt;
            logic             unused_msb;

            assign unused_msb = msb_c;

            if (k == 0) begin : g_fsrc
                assign a_nxt = bus.a[WIDTH-1:STAGE_W];
                assign b_nxt = bus.b[WIDTH-1:STAGE_W];
            end else begin : g_fsrc
                assign a_nxt = g_stage[k-1].g_mid.a_q[FWD_W+STAGE_W-1:STAGE_W];
                assign b_nxt = g_stage[k-1].g_mid.b_q[FWD_W+STAGE_W-1:STAGE_W];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_nxt;
                    b_q <= b_nxt;
                end
            end
        end else begin : g_last
            logic ovf_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q <= msb_c ^ slice_c;
                end
            end
        end
    end

    assign stall         = g_stage[STAGES-1].v_q & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.s         = g_stage[STAGES-1].sum_q;
    assign bus.cout      = g_stage[STAGES-1].c_q;
    assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed vector table, scoreboard-checked
// streams, backpressure, bubbles and asynchronous reset mid-stream.
module tb_pipe_adder;
    import adder_pkg::*;

    localparam int W  = 16;
    localparam int SW = 4;
    localparam int ST = W / SW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_adder_if #(.WIDTH(W)) bus16 ();
    pipe_adder_if #(.WIDTH(4)) bus4 ();

    pipe_adder #(.WIDTH(W), .STAGE_W(SW)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    pipe_adder #(.WIDTH(4), .STAGE_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t        vecs[7];
    logic [17:0] sb_q[$];
    int          run_cur = 0;
    int          run_max = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result packed as {cout, ovf, s}; overflow from operand/result signs.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin);
        logic [16:0] t;
        logic        o;
        t = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        o = (a[15] == b[15]) && (t[15] != a[15]);
        return {t[16], o, t[15:0]};
    endfunction

    always @(negedge clk) begin
        logic [17:0] exp_r;
        if (bus16.out_valid && bus16.out_ready) begin
            if (sb_q.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL sb_unexpected: got result s=0x%0h with no op outstanding (t=%0t)",
                         bus16.s, $time);
            end else begin
                exp_r = sb_q.pop_front();
                check("sb_result", {14'd0, bus16.cout, bus16.ovf, bus16.s}, {14'd0, exp_r});
            end
        end
        if (bus16.in_valid && bus16.in_ready && !rst)
            sb_q.push_back(model(bus16.a, bus16.b, bus16.cin));
        if (bus16.out_valid) run_cur++;
        else run_cur = 0;
        if (run_cur > run_max) run_max = run_cur;
    end

    task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b,
                           input logic c);
        bus16.in_valid = v;
        bus16.a        = a;
        bus16.b        = b;
        bus16.cin      = c;
    endtask

    task automatic wait_out16(output int lat);
        lat = 1;
        while (!bus16.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] held_s;
        logic        held_c;
        logic        held_o;
        logic        pat[5];
        logic        exp_ov[9];
        logic        ov[9];

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};

        drive16(1'b0, 16'h0, 16'h0, 1'b0);
        bus16.out_ready = 1'b1;
        bus4.in_valid   = 1'b0;
        bus4.a          = 4'h0;
        bus4.b          = 4'h0;
        bus4.cin        = 1'b0;
        bus4.out_ready  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", bus16.out_valid, 0);
        check("rst_s", bus16.s, 0);
        check("rst_cout", bus16.cout, 0);
        check("rst_ovf", bus16.ovf, 0);
        check("rst_in_ready", bus16.in_ready, 1);
        check("rst_out_valid_w4", bus4.out_valid, 0);

        // Directed vectors, one at a time, with latency measurement
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            drive16(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
            @(posedge clk);
            #1;
            bus16.in_valid = 1'b0;
            wait_out16(lat);
            check("vec_latency", lat, ST);
            check("vec_s", bus16.s, vecs[i].s);
            check("vec_cout", bus16.cout, vecs[i].cout);
            check("vec_ovf", bus16.ovf, vecs[i].ovf);
        end

        // Single-stage configuration
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b1;
        bus4.a        = 4'b1001;
        bus4.b        = 4'b1110;
        bus4.cin      = 1'b1;
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        check("w4_out_valid", bus4.out_valid, 1);
        check("w4_s", bus4.s, 4'b1000);
        check("w4_cout", bus4.cout, 1);
        check("w4_ovf", bus4.ovf, 0);
        @(posedge clk);
        #1;
        check("w4_drained", bus4.out_valid, 0);

        // Eight back-to-back random ops
        repeat (2) @(posedge clk);
        #1;
        run_max = 0;
        for (int i = 0; i < 8; i++) begin
            drive16(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
        end
        bus16.in_valid = 1'b0;
        repeat (ST + 2) @(posedge clk);
        #1;
        check("stream_run", run_max, 8);
        check("stream_sb_empty", sb_q.size(), 0);

        // Backpressure with a full pipe
        for (int i = 0; i < ST; i++) begin
            drive16(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
        end
        check("bp_full_valid", bus16.out_valid, 1);
        bus16.out_ready = 1'b0;
        drive16(1'b1, 16'h5A5A, 16'hA5A6, 1'b0);
        held_s = bus16.s;
        held_c = bus16.cout;
        held_o = bus16.ovf;
        for (int j = 0; j < 3; j++) begin
            #1;
            check("bp_in_ready", bus16.in_ready, 0);
            @(posedge clk);
            #1;
            check("bp_out_valid", bus16.out_valid, 1);
            check("bp_s_frozen", bus16.s, held_s);
            check("bp_flags_frozen", {bus16.cout, bus16.ovf}, {held_c, held_o});
        end
        bus16.out_ready = 1'b1;
        #1;
        check("bp_release_ready", bus16.in_ready, 1);
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
        repeat (ST + 3) @(posedge clk);
        #1;
        check("bp_sb_empty", sb_q.size(), 0);

        // Bubble pattern 1,0,1,1,0
        pat    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_ov = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        drive16(pat[0], 16'($urandom), 16'($urandom), 1'($urandom));
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            ov[i] = bus16.out_valid;
            if (i + 1 < 5) drive16(pat[i+1], 16'($urandom), 16'($urandom), 1'($urandom));
            else bus16.in_valid = 1'b0;
        end
        for (int i = 0; i < 9; i++) check("bubble_out_valid", ov[i], exp_ov[i]);
        repeat (2) @(posedge clk);
        #1;
        check("bubble_sb_empty", sb_q.size(), 0);

        // Asynchronous reset with ops in flight
        for (int i = 0; i < ST; i++) begin
            drive16(1'b1, 16'hFFFF - 16'(i), 16'h0002, 1'b0);
            @(posedge clk);
            #1;
        end
        bus16.in_valid = 1'b0;
        check("ars_pre_valid", bus16.out_valid, 1);
        check("ars_pre_s", bus16.s, 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        check("ars_out_valid", bus16.out_valid, 0);
        check("ars_s", bus16.s, 0);
        check("ars_cout", bus16.cout, 0);
        check("ars_in_ready", bus16.in_ready, 1);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive16(1'b1, 16'h0001, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
        wait_out16(lat);
        check("ars_new_latency", lat, ST);
        check("ars_new_s", bus16.s, 16'h0002);
        repeat (ST + 3) @(posedge clk);
        #1;
        check("ars_sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
